seq_party_select_acc: RTL and testbench

- Parametrised successor of the 1-bit garbler/evaluator select-and-mask sequential test circuit, in the sequential garbled-circuit netlist library.
- Each cycle, a registered select bit chooses the garbler (g_input) or evaluator (e_input) word.
- The chosen word updates two party-seeded state banks, optionally in an additive mode.
- A run lasts exactly CC clock cycles, framed by a start/done handshake, with a stall input.

---
 rtl/seq_party_select_acc.sv | 115 +++++++++++
 tb/tb_seq_party_select_acc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_party_select_acc.sv
// Sequential garbler/evaluator select-and-accumulate block.
// A registered select bit picks one party's word each step to update two seeded state banks.
module seq_party_select_acc #(
    parameter int WIDTH    = 8,
    parameter int CC       = 16,
    parameter int MODE     = 0,
    parameter int SEL_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [WIDTH-1:0] g_init,
    input  logic [WIDTH-1:0] e_init,
    input  logic [WIDTH-1:0] g_input,
    input  logic [WIDTH-1:0] e_input,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (CC > 1) ? $clog2(CC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CC - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state;
    logic             sel_q;
    logic [WIDTH-1:0] acc_g;
    logic [WIDTH-1:0] acc_e;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] ng;
    logic [WIDTH-1:0] ne;
    logic [WIDTH-1:0] r;

    // Next-state of both banks for one evaluation step; only the selected party's bank moves in add mode.
    always_comb begin
        p  = sel_q ? g_input : e_input;
        ng = acc_g;
        ne = acc_e;
        r  = '0;
        if (MODE == 0) begin
            ng = acc_g & p;
            ne = acc_e & ~p;
            r  = ng | ne;
        end else begin
            if (sel_q) begin
                ng = acc_g + p;
                r  = ng;
            end else begin
                ne = acc_e + p;
                r  = ne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sel_q   <= 1'b0;
            acc_g   <= '0;
            acc_e   <= '0;
            cnt     <= '0;
            o       <= '0;
            o_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    acc_g <= g_init;
                    acc_e <= e_init;
                    sel_q <= (SEL_INIT != 0);
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    // en low is a full stall: nothing in the datapath or the step count moves.
                    if (en) begin
                        acc_g   <= ng;
                        acc_e   <= ne;
                        o       <= r;
                        o_valid <= 1'b1;
                        sel_q   <= ^p;
                        if (cnt == LAST_CNT) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_party_select_acc.sv
// Randomised self-checking bench for seq_party_select_acc across four parameter sets.
// A per-step arithmetic reference model predicts o, o_valid, busy and done.
module tb_seq_party_select_acc;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start_t [4];
    logic       en_t    [4];
    logic [7:0] g_init_t[4];
    logic [7:0] e_init_t[4];
    logic [7:0] g_in_t  [4];
    logic [7:0] e_in_t  [4];

    logic [7:0] o0, o1, o2;
    logic [0:0] o3;
    logic       ov0, ov1, ov2, ov3;
    logic       bs0, bs1, bs2, bs3;
    logic       dn0, dn1, dn2, dn3;

    int checks = 0;
    int failures = 0;

    int         mg, me, ms;
    logic [7:0] mo[4];

    seq_party_select_acc #(.WIDTH(8), .CC(4), .MODE(0), .SEL_INIT(1)) dut_mask (
        .clk(clk), .rst(rst), .start(start_t[0]), .en(en_t[0]),
        .g_init(g_init_t[0]), .e_init(e_init_t[0]), .g_input(g_in_t[0]), .e_input(e_in_t[0]),
        .o(o0), .o_valid(ov0), .busy(bs0), .done(dn0));

    seq_party_select_acc #(.WIDTH(8), .CC(3), .MODE(1), .SEL_INIT(1)) dut_add (
        .clk(clk), .rst(rst), .start(start_t[1]), .en(en_t[1]),
        .g_init(g_init_t[1]), .e_init(e_init_t[1]), .g_input(g_in_t[1]), .e_input(e_in_t[1]),
        .o(o1), .o_valid(ov1), .busy(bs1), .done(dn1));

    seq_party_select_acc #(.WIDTH(8), .CC(2), .MODE(1), .SEL_INIT(0)) dut_switch (
        .clk(clk), .rst(rst), .start(start_t[2]), .en(en_t[2]),
        .g_init(g_init_t[2]), .e_init(e_init_t[2]), .g_input(g_in_t[2]), .e_input(e_in_t[2]),
        .o(o2), .o_valid(ov2), .busy(bs2), .done(dn2));

    seq_party_select_acc #(.WIDTH(1), .CC(8), .MODE(0), .SEL_INIT(0)) dut_bit (
        .clk(clk), .rst(rst), .start(start_t[3]), .en(en_t[3]),
        .g_init(g_init_t[3][0:0]), .e_init(e_init_t[3][0:0]),
        .g_input(g_in_t[3][0:0]), .e_input(e_in_t[3][0:0]),
        .o(o3), .o_valid(ov3), .busy(bs3), .done(dn3));

    function automatic int ccOf(input int id);
        case (id)
            0: return 4;
            1: return 3;
            2: return 2;
            default: return 8;
        endcase
    endfunction

    function automatic int modeOf(input int id);
        return (id == 1 || id == 2) ? 1 : 0;
    endfunction

    function automatic int selOf(input int id);
        return (id == 0 || id == 1) ? 1 : 0;
    endfunction

    function automatic int widthOf(input int id);
        return (id == 3) ? 1 : 8;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic readOut(input int id, output logic [7:0] o, output logic v, output logic b, output logic d);
        case (id)
            0: begin o = o0; v = ov0; b = bs0; d = dn0; end
            1: begin o = o1; v = ov1; b = bs1; d = dn1; end
            2: begin o = o2; v = ov2; b = bs2; d = dn2; end
            default: begin o = {7'b0, o3}; v = ov3; b = bs3; d = dn3; end
        endcase
    endtask

    // Reference step: plain modular arithmetic, parity by popcount.
    task automatic modelStep(input int id, input int g, input int e);
        int m, p, ng, ne, r;
        m  = (1 << widthOf(id)) - 1;
        p  = (ms != 0) ? g : e;
        ng = mg;
        ne = me;
        if (modeOf(id) == 0) begin
            ng = mg & p;
            ne = me & ~p & m;
            r  = ng | ne;
        end else if (ms != 0) begin
            ng = (mg + p) % (m + 1);
            r  = ng;
        end else begin
            ne = (me + p) % (m + 1);
            r  = ne;
        end
        mg = ng;
        me = ne;
        mo[id] = 8'(r);
        ms = $countones(p) % 2;
    endtask

    task automatic applyStimulus(input int id, input int gi, input int ei, input bit rnd,
                                 input int fixG, input int fixE, input int stallAt, input int stallLen,
                                 input int pokeAt, input int abortAt);
        logic [7:0] o;
        logic v, b, d;
        int steps, stall, guard, msk, gw, ew;
        bit doEn;
        msk = (1 << widthOf(id)) - 1;
        g_init_t[id] = 8'(gi & msk);
        e_init_t[id] = 8'(ei & msk);
        start_t[id] = 1'b1;
        en_t[id] = 1'b1;
        @(posedge clk); #1;
        start_t[id] = 1'b0;
        readOut(id, o, v, b, d);
        checkOutput("load_busy", b, 1);
        checkOutput("load_valid", v, 0);
        checkOutput("load_o_held", o, mo[id]);
        @(posedge clk); #1;
        readOut(id, o, v, b, d);
        checkOutput("run_entry_busy", b, 1);
        checkOutput("run_entry_valid", v, 0);
        mg = gi & msk;
        me = ei & msk;
        ms = selOf(id);
        steps = 0;
        stall = 0;
        guard = 0;
        while (steps < ccOf(id) && guard < 200) begin
            guard++;
            if (steps == abortAt) begin
                rst = 1'b0;
                #1;
                readOut(id, o, v, b, d);
                checkOutput("abort_o", o, 0);
                checkOutput("abort_valid", v, 0);
                checkOutput("abort_busy", b, 0);
                checkOutput("abort_done", d, 0);
                rst = 1'b1;
                for (int k = 0; k < 4; k++) mo[k] = 8'h00;
                start_t[id] = 1'b0;
                @(posedge clk); #1;
                readOut(id, o, v, b, d);
                checkOutput("abort_no_done", d, 0);
                checkOutput("abort_idle_busy", b, 0);
                return;
            end
            if (steps == stallAt && stall < stallLen) begin
                doEn = 1'b0;
                stall++;
            end else if (rnd) begin
                doEn = ($urandom_range(3) != 0);
            end else begin
                doEn = 1'b1;
            end
            gw = rnd ? (int'($urandom) & msk) : fixG;
            ew = rnd ? (int'($urandom) & msk) : fixE;
            g_in_t[id] = 8'(gw);
            e_in_t[id] = 8'(ew);
            en_t[id] = doEn;
            start_t[id] = (steps == pokeAt);
            @(posedge clk); #1;
            if (doEn) begin
                modelStep(id, gw, ew);
                steps++;
            end
            readOut(id, o, v, b, d);
            checkOutput("o_valid", v, doEn);
            checkOutput(doEn ? "o" : "o_stall_held", o, mo[id]);
            checkOutput("done", d, steps == ccOf(id));
            checkOutput("busy", b, steps < ccOf(id));
        end
        if (guard >= 200) checkOutput("run_timeout", steps, ccOf(id));
        start_t[id] = 1'b0;
        en_t[id] = 1'b1;
        @(posedge clk); #1;
        readOut(id, o, v, b, d);
        checkOutput("idle_done", d, 0);
        checkOutput("idle_valid", v, 0);
        checkOutput("idle_busy", b, 0);
        checkOutput("idle_o_held", o, mo[id]);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] o;
        logic v, b, d;
        for (int k = 0; k < 4; k++) begin
            start_t[k] = 1'b0; en_t[k] = 1'b0;
            g_init_t[k] = 8'h00; e_init_t[k] = 8'h00;
            g_in_t[k] = 8'h00; e_in_t[k] = 8'h00;
            mo[k] = 8'h00;
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            readOut(k, o, v, b, d);
            checkOutput("reset_o", o, 0);
            checkOutput("reset_valid", v, 0);
            checkOutput("reset_busy", b, 0);
            checkOutput("reset_done", d, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(0, 'hFF, 'hFF, 0, 'h0F, 'hF0, -1, 0, -1, -1);
        checkOutput("mask_final_o", mo[0], 8'h00);
        applyStimulus(0, 'hFF, 'hFF, 0, 'h0F, 'hF0, 2, 3, -1, -1);
        applyStimulus(1, 'hFE, 'h20, 0, 'h01, 'h03, -1, 0, -1, -1);
        checkOutput("add_wrap_o", mo[1], 8'h01);
        checkOutput("add_acc_e_kept", me, 'h20);
        applyStimulus(2, 'h40, 'h10, 0, 'h02, 'h01, -1, 0, -1, -1);
        checkOutput("switch_o", mo[2], 8'h42);
        applyStimulus(0, 'hFF, 'hFF, 0, 'h0F, 'hF0, -1, 0, 1, -1);
        applyStimulus(1, 'hFE, 'h20, 0, 'h01, 'h03, -1, 0, -1, 1);
        applyStimulus(1, 'hFE, 'h20, 0, 'h01, 'h03, -1, 0, -1, -1);
        repeat (4) applyStimulus(3, int'($urandom), int'($urandom), 1, 0, 0, -1, 0, -1, -1);
        for (int id = 0; id < 3; id++) begin
            repeat (3) applyStimulus(id, int'($urandom), int'($urandom), 1, 0, 0, -1, 0, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
